// File: rtl/core_pkg.sv
// Shared core encodings: write-back source select, load funct3 codes and
// the write-back unit state type.
package core_pkg;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_PC4  = 2'b01;
  localparam logic [1:0] WB_IMM  = 2'b10;
  localparam logic [1:0] WB_LOAD = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

endpackage

// File: rtl/load_align_ext.sv
// Combinational load data aligner: shifts the addressed field down, sign- or
// zero-extends it, and flags illegal funct3 or misaligned offsets.
module load_align_ext
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  i_rdata,
  input  logic [2:0]       i_funct3,
  input  logic [OFF_W-1:0] i_offset,
  output logic [XLEN-1:0]  o_data,
  output logic             o_bad
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_data = '0;
    o_bad  = 1'b0;
    case (i_funct3)
      F3_LB:  o_data = XLEN'($signed(w_shifted[7:0]));
      F3_LBU: o_data = XLEN'(w_shifted[7:0]);
      F3_LH: begin
        o_data = XLEN'($signed(w_shifted[15:0]));
        o_bad  = i_offset[0];
      end
      F3_LHU: begin
        o_data = XLEN'(w_shifted[15:0]);
        o_bad  = i_offset[0];
      end
      F3_LW: begin
        o_data = XLEN'($signed(w_shifted[31:0]));
        o_bad  = (i_offset[1:0] != 2'b00);
      end
      F3_LWU: begin
        o_data = XLEN'(w_shifted[31:0]);
        o_bad  = (XLEN != 64) || (i_offset[1:0] != 2'b00);
      end
      F3_LD: begin
        o_data = w_shifted;
        o_bad  = (XLEN != 64) || (i_offset != '0);
      end
      default: o_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_select_unit.sv
// Registered write-back stage: selects ALU/PC+4/imm/load data and drives the
// register-file write port one cycle later; loads wait for memory with timeout.
module wb_select_unit
  import core_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int OFF_W          = $clog2(XLEN/8)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            wb_sel,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       pc,
  input  logic [XLEN-1:0]       imm,
  input  logic [2:0]            load_funct3,
  input  logic [OFF_W-1:0]      byte_offset,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  load_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                r_state;
  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_waddr;
  logic [XLEN-1:0]       r_rf_wdata;
  logic                  r_load_err;
  logic [CNT_W-1:0]      r_cnt;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_reg_write;
  logic [2:0]            r_funct3;
  logic [OFF_W-1:0]      r_offset;

  logic                  w_accept;
  logic                  w_nl_we;
  logic [XLEN-1:0]       w_nl_data;
  logic [2:0]            w_funct3;
  logic [OFF_W-1:0]      w_offset;
  logic [XLEN-1:0]       w_ld_data;
  logic                  w_ld_bad;
  logic                  w_timeout;

  assign in_ready  = (r_state == IDLE);
  assign w_accept  = in_valid & in_ready;
  assign w_nl_we   = reg_write & (rd_addr != '0);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // One aligner serves both the accept-time legality check and the response.
  assign w_funct3 = (r_state == IDLE) ? load_funct3 : r_funct3;
  assign w_offset = (r_state == IDLE) ? byte_offset : r_offset;

  always_comb begin
    w_nl_data = alu_result;
    case (wb_sel)
      WB_PC4:  w_nl_data = pc + XLEN'(4);
      WB_IMM:  w_nl_data = imm;
      default: w_nl_data = alu_result;
    endcase
  end

  load_align_ext #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_align (
    .i_rdata  (mem_rdata),
    .i_funct3 (w_funct3),
    .i_offset (w_offset),
    .o_data   (w_ld_data),
    .o_bad    (w_ld_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rf_we     <= 1'b0;
      r_rf_waddr  <= '0;
      r_rf_wdata  <= '0;
      r_load_err  <= 1'b0;
      r_cnt       <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_funct3    <= '0;
      r_offset    <= '0;
    end else begin
      r_rf_we    <= 1'b0;
      r_load_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (wb_sel != WB_LOAD) begin
              if (w_nl_we) begin
                r_rf_we    <= 1'b1;
                r_rf_waddr <= rd_addr;
                r_rf_wdata <= w_nl_data;
              end
            end else begin
              r_rd        <= rd_addr;
              r_reg_write <= reg_write;
              r_funct3    <= load_funct3;
              r_offset    <= byte_offset;
              if (w_ld_bad) begin
                r_load_err <= 1'b1;
              end else begin
                r_state <= WAIT_MEM;
                r_cnt   <= '0;
              end
            end
          end
        end
        WAIT_MEM: begin
          r_cnt <= r_cnt + 1'b1;
          // Data arriving on the timeout cycle still completes the load.
          if (mem_rvalid) begin
            r_state <= IDLE;
            if (r_reg_write && (r_rd != '0)) begin
              r_rf_we    <= 1'b1;
              r_rf_waddr <= r_rd;
              r_rf_wdata <= w_ld_data;
            end
          end else if (w_timeout) begin
            r_state    <= IDLE;
            r_load_err <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_wb_select_unit.sv
// Directed-vector bench for wb_select_unit at XLEN=32 with hand-computed
// expected write-back values.
module tb_wb_select_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  wb_sel;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [2:0]  load_funct3;
  logic [1:0]  byte_offset;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_select_unit #(
    .XLEN           (32),
    .REG_ADDR_W     (5),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .wb_sel      (wb_sel),
    .reg_write   (reg_write),
    .rd_addr     (rd_addr),
    .alu_result  (alu_result),
    .pc          (pc),
    .imm         (imm),
    .load_funct3 (load_funct3),
    .byte_offset (byte_offset),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .load_err    (load_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic rw,
                       input logic [31:0] val);
    wb_sel     = sel;
    rd_addr    = rd;
    reg_write  = rw;
    alu_result = val;
    pc         = val;
    imm        = val;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic issue_load(input logic [2:0] f3, input logic [1:0] off,
                            input logic [4:0] rd, input logic rw);
    wb_sel      = 2'b11;
    load_funct3 = f3;
    byte_offset = off;
    rd_addr     = rd;
    reg_write   = rw;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    mem_rdata  = data;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
  endtask

  // Load with a fixed wait, then check the written value.
  task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] data, input logic [31:0] exp);
    issue_load(f3, off, 5'd9, 1'b1);
    check({tag, " ready_wait"}, in_ready, 0);
    tick();
    tick();
    check({tag, " no_early_we"}, rf_we, 0);
    respond(data);
    check({tag, " we"}, rf_we, 1);
    check({tag, " waddr"}, rf_waddr, 9);
    check({tag, " wdata"}, rf_wdata, exp);
    check({tag, " ready_back"}, in_ready, 1);
    $display("load %s f3=%0d off=%0d data=%h -> %h", tag, f3, off, data, rf_wdata);
  endtask

  task automatic bad_load(input string tag, input logic [2:0] f3, input logic [1:0] off);
    issue_load(f3, off, 5'd6, 1'b1);
    check({tag, " err"}, load_err, 1);
    check({tag, " we"}, rf_we, 0);
    check({tag, " ready"}, in_ready, 1);
    tick();
    check({tag, " err_pulse"}, load_err, 0);
    $display("bad load %s f3=%0d off=%0d", tag, f3, off);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; wb_sel = 2'b00; reg_write = 1'b0; rd_addr = '0;
    alu_result = '0; pc = '0; imm = '0; load_funct3 = '0; byte_offset = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
    tick();
    check("rst we", rf_we, 0);
    check("rst waddr", rf_waddr, 0);
    check("rst wdata", rf_wdata, 0);
    check("rst err", load_err, 0);
    check("rst ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    issue(2'b00, 5'd5, 1'b1, 32'h1234_5678);
    check("alu we", rf_we, 1);
    check("alu waddr", rf_waddr, 5);
    check("alu wdata", rf_wdata, 32'h1234_5678);
    check("alu ready", in_ready, 1);
    $display("alu rd=5 -> %h", rf_wdata);
    tick();
    check("alu we_pulse", rf_we, 0);

    issue(2'b01, 5'd1, 1'b1, 32'hFFFF_FFFC);
    check("pc4 we", rf_we, 1);
    check("pc4 wdata", rf_wdata, 32'h0);
    $display("pc4 wrap rd=1 -> %h", rf_wdata);
    issue(2'b01, 5'd0, 1'b1, 32'h0000_1000);
    check("pc4 rd0 we", rf_we, 0);
    issue(2'b10, 5'd7, 1'b1, 32'hABCD_E000);
    check("imm wdata", rf_wdata, 32'hABCD_E000);
    check("imm waddr", rf_waddr, 7);
    issue(2'b00, 5'd8, 1'b0, 32'h1111_1111);
    check("nowrite we", rf_we, 0);
    check("nowrite hold", rf_wdata, 32'hABCD_E000);
    $display("imm/no-write sequence done");

    // back-to-back accepts
    issue(2'b00, 5'd3, 1'b1, 32'hAAAA_0003);
    check("b2b1 wdata", rf_wdata, 32'hAAAA_0003);
    issue(2'b01, 5'd4, 1'b1, 32'h0000_0100);
    check("b2b2 wdata", rf_wdata, 32'h0000_0104);
    check("b2b2 waddr", rf_waddr, 4);
    tick();

    load_case("lb", 3'b000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80);
    load_case("lbu", 3'b100, 2'd2, 32'h0080_0000, 32'h0000_0080);
    load_case("lh", 3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001);
    load_case("lhu", 3'b101, 2'd0, 32'h1234_ABCD, 32'h0000_ABCD);
    load_case("lw", 3'b010, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    load_case("lb3", 3'b000, 2'd3, 32'h7F00_0000, 32'h0000_007F);

    bad_load("lw_mis", 3'b010, 2'd1);
    bad_load("lh_mis", 3'b001, 2'd3);
    bad_load("ld_x32", 3'b011, 2'd0);
    bad_load("lwu_x32", 3'b110, 2'd0);
    bad_load("f3_111", 3'b111, 2'd0);

    // load with reg_write=0 completes but does not write
    issue_load(3'b010, 2'd0, 5'd12, 1'b0);
    respond(32'h5555_5555);
    check("ld_norw we", rf_we, 0);
    check("ld_norw ready", in_ready, 1);

    // timeout: 64 waiting cycles with no response
    issue_load(3'b010, 2'd0, 5'd10, 1'b1);
    for (int i = 0; i < 63; i++) tick();
    check("to early_err", load_err, 0);
    check("to early_ready", in_ready, 0);
    tick();
    check("to err", load_err, 1);
    check("to we", rf_we, 0);
    check("to ready", in_ready, 1);
    $display("timeout load rd=10 err=%0d", load_err);
    tick();
    check("to err_pulse", load_err, 0);

    // response on the 64th waiting cycle wins over timeout
    issue_load(3'b010, 2'd0, 5'd11, 1'b1);
    for (int i = 0; i < 63; i++) tick();
    respond(32'h0000_0055);
    check("to_edge we", rf_we, 1);
    check("to_edge wdata", rf_wdata, 32'h0000_0055);
    check("to_edge err", load_err, 0);
    $display("edge-timeout load rd=11 -> %h", rf_wdata);
    tick();

    // rvalid while idle is ignored
    respond(32'hCAFE_F00D);
    check("idle_rvalid we", rf_we, 0);
    check("idle_rvalid ready", in_ready, 1);

    // reset mid-load
    issue_load(3'b010, 2'd0, 5'd13, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst ready", in_ready, 1);
    check("midrst wdata", rf_wdata, 0);
    check("midrst waddr", rf_waddr, 0);
    check("midrst err", load_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    respond(32'h1234_0000);
    check("midrst late_we", rf_we, 0);
    check("midrst late_err", load_err, 0);
    $display("reset mid-load done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_select_unit.md
Name: wb_select_unit

Overview:
- Registered write-back unit for the pipelined core. It replaces the combinational register-file data mux.
- Accepts one retiring instruction per handshake and selects the write data from one of four sources: ALU, PC+4, upper immediate, or load.
- For loads it waits for the memory response, then aligns and sign- or zero-extends the data. A load that never returns or is misaligned is reported as an error.
- It drives the register-file write port one cycle after the result is known.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- REG_ADDR_W, 5, register address width.
- TIMEOUT_CYCLES, 64, WAIT_MEM cycles before a load is abandoned; minimum 1.
- OFF_W, $clog2(XLEN/8), derived width of the byte-offset field.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  retiring instruction present.
- in_ready  out  1  unit can accept an instruction.
- wb_sel  in  2  source select: 00 ALU, 01 PC+4, 10 imm, 11 load.
- reg_write  in  1  instruction writes rd.
- rd_addr  in  REG_ADDR_W  destination register.
- alu_result  in  XLEN  ALU output.
- pc  in  XLEN  instruction PC.
- imm  in  XLEN  LUI immediate, already shifted.
- load_funct3  in  3  load type.
- byte_offset  in  OFF_W  low address bits of the load.
- mem_rvalid  in  1  load data valid, single-cycle pulse.
- mem_rdata  in  XLEN  load data, naturally aligned word or doubleword.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_ADDR_W  write address.
- rf_wdata  out  XLEN  write data.
- load_err  out  1  one-cycle pulse on misaligned, illegal-funct3 or timed-out load.

Behaviour:
- Reset (async assert, sync release): state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, load_err=0, timeout counter=0. in_ready=1 after reset.
- States: IDLE and WAIT_MEM. in_ready=1 only in IDLE. An instruction is accepted on in_valid & in_ready.
- IDLE, accepting a non-load (wb_sel≠11):
  - Next edge: rf_we=reg_write & (rd_addr≠0), rf_waddr=rd_addr.
  - rf_wdata = alu_result, pc+4 (mod 2^XLEN, wraps), or imm.
  - Latency 1 cycle. Stays in IDLE, so back-to-back accepts are allowed.
- IDLE, accepting a load:
  - Capture rd_addr, reg_write, funct3, byte_offset.
  - If funct3 is illegal or the access is misaligned: pulse load_err next cycle, no write, stay IDLE.
  - Otherwise go to WAIT_MEM and clear the counter.
- Legal funct3 values:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (all XLEN).
  - 011 LD and 110 LWU only when XLEN=64.
  - Others are illegal.
- Misalignment: halfword needs offset[0]=0; word needs offset[1:0]=0; doubleword needs offset=0.
- WAIT_MEM:
  - The counter increments each cycle.
  - On mem_rvalid: field = mem_rdata >> (8*byte_offset), truncated to the access size. Sign-extend for LB/LH/LW(XLEN=64), zero-extend for LBU/LHU/LWU.
  - Register the write (rf_we gated by reg_write and rd≠0) on the next edge, return to IDLE.
  - If the counter reaches TIMEOUT_CYCLES without mem_rvalid: pulse load_err, no write, return to IDLE.
  - If mem_rvalid coincides with the timeout cycle, the data wins and no error is raised.
- mem_rvalid received in IDLE is ignored.
- rf_we and load_err are single-cycle pulses; default 0 every cycle not producing them. rf_waddr/rf_wdata hold their last values when rf_we=0.
- Reset asserted mid-WAIT_MEM: immediate return to IDLE, no write, no error.

Decomposition:
- Shared package core_pkg:
  - wb_sel encoding constants (WB_ALU, WB_PC4, WB_IMM, WB_LOAD).
  - funct3 load constants (F3_LB…F3_LWU).
  - state enum {IDLE, WAIT_MEM}.
- One natural sub-module: load_align_ext. It is purely combinational, takes rdata, funct3 and offset, and outputs the aligned data plus an illegal/misaligned flag. It is reused by the future LSU.

Test Plan:
- ALU write: in_valid, wb_sel=00, rd=5, alu_result=0x1234_5678 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678; in_ready stays 1.
- PC+4 wrap: wb_sel=01, pc=0xFFFF_FFFC, rd=1 -> rf_wdata=0x0000_0000, rf_we=1. Same with rd=0 -> rf_we=0.
- LB sign extension: funct3=000, offset=2, then mem_rvalid after 3 cycles with rdata=0x0080_0000 -> in_ready=0 during wait, then rf_wdata=0xFFFF_FF80. With LBU (100) -> 0x0000_0080.
- Misaligned and illegal loads: LW offset=1 -> load_err pulse, no rf_we, in_ready stays 1. funct3=011 at XLEN=32 -> load_err.
- Timeout: load accepted, no mem_rvalid -> load_err pulse after TIMEOUT_CYCLES=64 cycles, no write, back to IDLE. Repeat with mem_rvalid on exactly cycle 64 -> write occurs, no error.
- Reset mid-load: assert rst_n=0 in WAIT_MEM -> outputs 0 and IDLE immediately; a later mem_rvalid produces no write.
